// File: rtl/dispatch_pkg.sv
// Shared types and constants for the CPU address dispatcher: region/select encodings,
// default page numbers and IO register offsets.
package dispatch_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_UNMAPPED
  } regionT;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LR,
    SEL_UD,
    SEL_COLOR,
    SEL_ACCEL
  } selT;

  localparam logic [7:0]  RAM_PAGE_DEF = 8'h00;
  localparam logic [7:0]  IO_PAGE_DEF  = 8'hFF;

  localparam logic [15:0] IO_OFS_LR    = 16'h0000;
  localparam logic [15:0] IO_OFS_UD    = 16'h0001;
  localparam logic [15:0] IO_OFS_COLOR = 16'h0002;
  localparam logic [15:0] IO_OFS_ACCEL = 16'h0003;

endpackage

// File: rtl/dispatch.sv
// Routes CPU accesses to RAM or read-only IO snapshots; read data is one clock after address
// for every region, matching the RAM. No backpressure: a new access is accepted every cycle.
module dispatch
  import dispatch_pkg::*;
#(
  parameter logic [7:0] RAM_PAGE = RAM_PAGE_DEF,
  parameter logic [7:0] IO_PAGE  = IO_PAGE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] Address,
  input  logic [15:0] RAMData,
  input  logic [15:0] encLR,
  input  logic [15:0] encUD,
  input  logic [15:0] encColor,
  input  logic [15:0] accelFlag,
  input  logic        weIn,
  input  logic [15:0] WriteDataIn,
  output logic [15:0] WriteDataOut,
  output logic [15:0] ReadDataOut,
  output logic        weOut,
  output logic [15:0] AddressOut
);

  function automatic regionT decodeRegion(input logic [23:0] addr);
    if (addr[23:16] == RAM_PAGE)     return REGION_RAM;
    else if (addr[23:16] == IO_PAGE) return REGION_IO;
    else                             return REGION_UNMAPPED;
  endfunction

  function automatic selT decodeSel(input logic [23:0] addr);
    case (decodeRegion(addr))
      REGION_RAM: return SEL_RAM;
      REGION_IO: begin
        case (addr[15:0])
          IO_OFS_LR:    return SEL_LR;
          IO_OFS_UD:    return SEL_UD;
          IO_OFS_COLOR: return SEL_COLOR;
          IO_OFS_ACCEL: return SEL_ACCEL;
          default:      return SEL_NONE;
        endcase
      end
      default: return SEL_NONE;
    endcase
  endfunction

  regionT      region;
  selT         selQ;
  logic [15:0] lrQ, udQ, colorQ, accelQ;

  assign region       = decodeRegion(Address);
  assign AddressOut   = Address[15:0];
  assign WriteDataOut = WriteDataIn;
  // IO registers are read-only, so writes outside RAM never reach the bus
  assign weOut        = (region == REGION_RAM) ? weIn : 1'b0;

  // Encoders are sampled every edge so IO reads line up with the RAM's one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selQ   <= SEL_NONE;
      lrQ    <= 16'h0000;
      udQ    <= 16'h0000;
      colorQ <= 16'h0000;
      accelQ <= 16'h0000;
    end else begin
      selQ   <= decodeSel(Address);
      lrQ    <= encLR;
      udQ    <= encUD;
      colorQ <= encColor;
      accelQ <= accelFlag;
    end
  end

  always_comb begin
    ReadDataOut = 16'h0000;
    case (selQ)
      SEL_RAM:   ReadDataOut = RAMData;
      SEL_LR:    ReadDataOut = lrQ;
      SEL_UD:    ReadDataOut = udQ;
      SEL_COLOR: ReadDataOut = colorQ;
      SEL_ACCEL: ReadDataOut = accelQ;
      default:   ReadDataOut = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_dispatch.sv
// Directed plus randomized bench for dispatch against a page/offset reference model.
module tb_dispatch;

  localparam logic [7:0] RAM_PG = 8'h00;
  localparam logic [7:0] IO_PG  = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] Address;
  logic [15:0] RAMData, encLR, encUD, encColor, accelFlag, WriteDataIn;
  logic        weIn;
  logic [15:0] WriteDataOut, ReadDataOut, AddressOut;
  logic        weOut;

  int checks = 0;
  int errors = 0;

  dispatch #(.RAM_PAGE(RAM_PG), .IO_PAGE(IO_PG)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .RAMData(RAMData),
    .encLR(encLR), .encUD(encUD), .encColor(encColor), .accelFlag(accelFlag),
    .weIn(weIn), .WriteDataIn(WriteDataIn), .WriteDataOut(WriteDataOut),
    .ReadDataOut(ReadDataOut), .weOut(weOut), .AddressOut(AddressOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what the CPU should read back for an access made with these source values
  function automatic logic [15:0] expRead(input logic [23:0] a, input logic [15:0] ram,
                                          input logic [15:0] lr, input logic [15:0] ud,
                                          input logic [15:0] col, input logic [15:0] acc);
    logic [15:0] regs [4];
    regs[0] = lr; regs[1] = ud; regs[2] = col; regs[3] = acc;
    if (a[23:16] == RAM_PG) return ram;
    if (a[23:16] == IO_PG && a[15:0] < 16'd4) return regs[a[1:0]];
    return 16'h0000;
  endfunction

  // One access: present inputs, check combinational outputs, clock, check read result,
  // then disturb the encoder inputs to show the read comes from the captured snapshot.
  task automatic step(input logic [23:0] a, input logic we, input logic [15:0] wd,
                      input logic [15:0] ram, input logic [15:0] lr, input logic [15:0] ud,
                      input logic [15:0] col, input logic [15:0] acc);
    logic [15:0] exp;
    Address = a; weIn = we; WriteDataIn = wd; RAMData = ram;
    encLR = lr; encUD = ud; encColor = col; accelFlag = acc;
    #1;
    chk("AddressOut", AddressOut, a[15:0]);
    chk("WriteDataOut", WriteDataOut, wd);
    chk("weOut", {15'd0, weOut}, {15'd0, (a[23:16] == RAM_PG) ? we : 1'b0});
    exp = expRead(a, ram, lr, ud, col, acc);
    @(posedge clk); #1;
    chk("read", ReadDataOut, exp);
    encLR = 16'($urandom); encUD = 16'($urandom);
    encColor = 16'($urandom); accelFlag = 16'($urandom);
    #1;
    chk("snapshot hold", ReadDataOut, exp);
  endtask

  initial begin
    logic [23:0] a;
    logic [7:0]  pg;
    rst_n = 1'b0;
    Address = 24'hFF0000; RAMData = 16'h1111; weIn = 1'b1; WriteDataIn = 16'hBEEF;
    encLR = 16'h00AA; encUD = 16'h00BB; encColor = 16'h00CC; accelFlag = 16'h00DD;

    // Reset state: read path forced to zero, combinational paths still live
    repeat (2) @(posedge clk);
    #1;
    chk("reset read io", ReadDataOut, 16'h0000);
    chk("reset weOut io", {15'd0, weOut}, 16'h0000);
    chk("reset WriteDataOut", WriteDataOut, 16'hBEEF);
    Address = 24'h000010;
    @(posedge clk); #1;
    chk("reset read ram", ReadDataOut, 16'h0000);
    chk("reset weOut ram", {15'd0, weOut}, 16'h0001);
    chk("reset AddressOut", AddressOut, 16'h0010);
    rst_n = 1'b1;

    // RAM read
    step(24'h000123, 1'b0, 16'h0000, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    // IO reads on consecutive clocks
    for (int i = 0; i < 4; i++) begin
      a = 24'hFF0000 + 24'(i);
      step(a, 1'b0, 16'h0000, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    end
    // Write protection and RAM write
    step(24'hFF0001, 1'b1, 16'hBEEF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    step(24'h000010, 1'b1, 16'hBEEF, 16'h4321, 16'd2, 16'd3, 16'd4, 16'd5);
    // Unmapped page and IO offset past the last register
    step(24'h7F0000, 1'b1, 16'h1234, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    step(24'hFF0004, 1'b1, 16'h1234, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
    // Alternating regions back to back
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? 24'h000200 + 24'(i) : 24'hFF0000 + 24'(i % 4);
      step(a, 1'b0, 16'h0000, 16'hA000 + 16'(i), 16'hB001, 16'hB002, 16'hB003, 16'hB004);
    end

    // Page sweep with a reset pulse in the middle
    for (int p = 0; p < 256; p++) begin
      pg = 8'(p);
      step({pg, 16'h0000}, 1'b0, 16'h0000, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
      if (p == 128) begin
        step(24'hFF0000, 1'b0, 16'h0000, 16'd1, 16'h0002, 16'd3, 16'd4, 16'd5);
        rst_n = 1'b0;
        #1;
        chk("async reset immediate", ReadDataOut, 16'h0000);
        Address = 24'hFF0000; encLR = 16'h0777;
        @(posedge clk); #1;
        chk("reset held", ReadDataOut, 16'h0000);
        rst_n = 1'b1;
        step(24'hFF0001, 1'b0, 16'h0000, 16'd1, 16'd2, 16'h0003, 16'd4, 16'd5);
      end
    end

    // Randomized traffic, biased toward the interesting pages and offsets
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       pg = RAM_PG;
        1, 2:    pg = IO_PG;
        default: pg = 8'($urandom);
      endcase
      a = {pg, ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom)};
      step(a, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
